// File: rtl/spx_pkg.sv
// spx_pkg: shared widths, colour IDs, source indices and issue-FSM state type
// for the superpixel request path.
package spx_pkg;

  localparam int SPIXEL_X_WIDTH = 5;
  localparam int SPIXEL_Y_WIDTH = 5;
  localparam int COLOR_ID_WIDTH = 8;

  localparam logic [7:0] COLOR_APPLE = 8'h11;
  localparam logic [7:0] COLOR_HEAD  = 8'hff;
  localparam logic [7:0] COLOR_BG    = 8'h0f;

  localparam int SRC_TAIL  = 0;
  localparam int SRC_HEAD  = 1;
  localparam int SRC_APPLE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } spx_state_e;

  // Lowest set bit wins, so tail-erase always beats head and apple draws.
  function automatic logic [2:0] first_onehot(input logic [2:0] req);
    if (req[0]) begin
      return 3'b001;
    end else if (req[1]) begin
      return 3'b010;
    end else if (req[2]) begin
      return 3'b100;
    end else begin
      return 3'b000;
    end
  endfunction

endpackage

// File: rtl/spx_req_fifo.sv
// spx_req_fifo: generic synchronous circular-buffer FIFO with push, pop,
// flush, occupancy count and full/empty flags.
module spx_req_fifo #(
  parameter int DW    = 18,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;

  // Pointers and count; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care while their slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign cnt   = cnt_r;
  assign full  = (cnt_r == CNT_MAX);
  assign empty = (cnt_r == '0);

endmodule

// File: rtl/spx_req_queue.sv
// spx_req_queue: fixed-priority arbiter + FIFO feeding the superpixel drawer one
// request at a time. Define SPX_REQ_TIMEOUT_EN to enable the WAIT watchdog.
module spx_req_queue #(
  parameter int          SPIXEL_X_WIDTH = spx_pkg::SPIXEL_X_WIDTH,
  parameter int          SPIXEL_Y_WIDTH = spx_pkg::SPIXEL_Y_WIDTH,
  parameter int          COLOR_ID_WIDTH = spx_pkg::COLOR_ID_WIDTH,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          FIFO_AW        = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  src_vld,
  input  logic [3*SPIXEL_X_WIDTH-1:0] src_x,
  input  logic [3*SPIXEL_Y_WIDTH-1:0] src_y,
  input  logic [3*COLOR_ID_WIDTH-1:0] src_color,
  output logic [2:0]                  src_ack,
  input  logic                        flush,
  output logic [SPIXEL_X_WIDTH-1:0]   ox,
  output logic [SPIXEL_Y_WIDTH-1:0]   oy,
  output logic [COLOR_ID_WIDTH-1:0]   odata,
  output logic                        odata_vld,
  input  logic                        idone,
  output logic                        busy,
  output logic [FIFO_AW:0]            fifo_cnt,
  output logic                        full,
  output logic                        timeout_err
);

  import spx_pkg::*;

  localparam int XW = SPIXEL_X_WIDTH;
  localparam int YW = SPIXEL_Y_WIDTH;
  localparam int CW = COLOR_ID_WIDTH;
  localparam int EW = XW + YW + CW;

  spx_state_e    state_r;
  spx_state_e    state_next_s;
  logic [2:0]    ack_s;
  logic [EW-1:0] wdata_s;
  logic [EW-1:0] rdata_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [FIFO_AW:0] fifo_cnt_s;
  logic          wd_expire_s;
  logic [XW-1:0] ox_r;
  logic [YW-1:0] oy_r;
  logic [CW-1:0] odata_r;
  logic          odata_vld_r;

  // Grant one source per cycle and select its packed fields as the FIFO entry.
  always_comb begin
    ack_s   = 3'b000;
    wdata_s = '0;
    if (!full_s && !flush) begin
      ack_s = first_onehot(src_vld);
    end else begin
      ack_s = 3'b000;
    end
    case (ack_s)
      3'b001:  wdata_s = {src_x[SRC_TAIL*XW +: XW],  src_y[SRC_TAIL*YW +: YW],  src_color[SRC_TAIL*CW +: CW]};
      3'b010:  wdata_s = {src_x[SRC_HEAD*XW +: XW],  src_y[SRC_HEAD*YW +: YW],  src_color[SRC_HEAD*CW +: CW]};
      3'b100:  wdata_s = {src_x[SRC_APPLE*XW +: XW], src_y[SRC_APPLE*YW +: YW], src_color[SRC_APPLE*CW +: CW]};
      default: wdata_s = '0;
    endcase
  end

  assign push_s = |ack_s;

  spx_req_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (wdata_s),
    .pop   (pop_s),
    .flush (flush),
    .rdata (rdata_s),
    .cnt   (fifo_cnt_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Issue FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; ISSUE and WAIT are not aborted by flush.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s) state_next_s = ISSUE;
        else       state_next_s = IDLE;
      end
      ISSUE: begin
        if (idone) state_next_s = IDLE;
        else       state_next_s = WAIT;
      end
      WAIT: begin
        if (idone || wd_expire_s) state_next_s = IDLE;
        else                      state_next_s = WAIT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode: pop the head entry from IDLE unless a flush wins.
  always_comb begin
    pop_s = 1'b0;
    if (state_r == IDLE && !empty_s && !flush) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Issued-request registers load on every pop and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox_r        <= '0;
      oy_r        <= '0;
      odata_r     <= '0;
      odata_vld_r <= 1'b0;
    end else begin
      odata_vld_r <= pop_s;
      if (pop_s) begin
        ox_r    <= rdata_s[EW-1 -: XW];
        oy_r    <= rdata_s[CW +: YW];
        odata_r <= rdata_s[CW-1:0];
      end
    end
  end

`ifdef SPX_REQ_TIMEOUT_EN
  logic [15:0] wd_cnt_r;
  logic        timeout_err_r;

  // Watchdog counts WAIT cycles from zero on each entry into WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r <= 16'd0;
    end else if (state_r == WAIT) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end else begin
      wd_cnt_r <= 16'd0;
    end
  end

  // Expiry fires in the TIMEOUT_CYCLES-th consecutive WAIT cycle.
  always_comb begin
    if (state_r == WAIT && wd_cnt_r == (TIMEOUT_CYCLES - 16'd1)) begin
      wd_expire_s = 1'b1;
    end else begin
      wd_expire_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else if (wd_expire_s) begin
      timeout_err_r <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign wd_expire_s = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign src_ack   = ack_s;
  assign ox        = ox_r;
  assign oy        = oy_r;
  assign odata     = odata_r;
  assign odata_vld = odata_vld_r;
  assign fifo_cnt  = fifo_cnt_s;
  assign full      = full_s;
  assign busy      = (state_r != IDLE) || !empty_s;

endmodule

// File: tb/tb_spx_req_queue.sv
// tb_spx_req_queue: table-driven arbitration vectors plus directed sequences for
// issue latency, priority order, full, flush, reset and (optionally) timeout.
module tb_spx_req_queue;
  import spx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_vld;
  logic [14:0] src_x;
  logic [14:0] src_y;
  logic [23:0] src_color;
  logic [2:0]  src_ack;
  logic        flush;
  logic [4:0]  ox;
  logic [4:0]  oy;
  logic [7:0]  odata;
  logic        odata_vld;
  logic        idone;
  logic        busy;
  logic [2:0]  fifo_cnt;
  logic        full;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int vld_cnt = 0;

  spx_req_queue #(.TIMEOUT_CYCLES(16'd10)) dut (
    .clk(clk), .rst(rst), .src_vld(src_vld), .src_x(src_x), .src_y(src_y),
    .src_color(src_color), .src_ack(src_ack), .flush(flush), .ox(ox), .oy(oy),
    .odata(odata), .odata_vld(odata_vld), .idone(idone), .busy(busy),
    .fifo_cnt(fifo_cnt), .full(full), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Count issue pulses completed by each rising edge.
  always @(posedge clk) begin
    if (odata_vld) vld_cnt++;
  end

  typedef struct packed {
    logic [2:0] vld;
    logic       flsh;
    logic [2:0] ack;
  } arb_vec_t;

  arb_vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_done();
    idone = 1'b1;
    cyc();
    idone = 1'b0;
  endtask

  task automatic set_src(input int s, input int x, input int y, input logic [7:0] c);
    src_x[s*5 +: 5]     = 5'(x);
    src_y[s*5 +: 5]     = 5'(y);
    src_color[s*8 +: 8] = c;
  endtask

  // Wait (bounded) for an issue pulse; returns positioned at the pulse's negedge.
  task automatic wait_issue(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (odata_vld) ok = 1'b1;
    end
  endtask

  // Hold the head request, advancing x after every ack, until n pushes land.
  task automatic push_head(input int n, input int x0);
    int acc;
    int guard;
    acc = 0;
    guard = 0;
    set_src(SRC_HEAD, x0, 3, COLOR_HEAD);
    src_vld = 3'b010;
    while (acc < n && guard < 40) begin
      @(negedge clk);
      if (src_ack == 3'b010) acc++;
      cyc();
      set_src(SRC_HEAD, x0 + acc, 3, COLOR_HEAD);
      guard++;
    end
    src_vld = 3'b000;
    check("push_count", acc, n);
  endtask

  initial begin
    bit ok;
    int v0;
    int bad;

    tbl[0] = '{3'b000, 1'b0, 3'b000};
    tbl[1] = '{3'b001, 1'b0, 3'b001};
    tbl[2] = '{3'b010, 1'b0, 3'b010};
    tbl[3] = '{3'b100, 1'b0, 3'b100};
    tbl[4] = '{3'b011, 1'b0, 3'b001};
    tbl[5] = '{3'b110, 1'b0, 3'b010};
    tbl[6] = '{3'b101, 1'b0, 3'b001};
    tbl[7] = '{3'b111, 1'b0, 3'b001};
    tbl[8] = '{3'b111, 1'b1, 3'b000};
    tbl[9] = '{3'b010, 1'b1, 3'b000};

    rst = 1'b1; src_vld = 3'b000; flush = 1'b0; idone = 1'b0;
    src_x = '0; src_y = '0; src_color = '0;
    set_src(SRC_TAIL, 1, 2, COLOR_BG);
    set_src(SRC_HEAD, 7, 3, COLOR_HEAD);
    set_src(SRC_APPLE, 20, 9, COLOR_APPLE);

    // Reset state
    @(negedge clk);
    check("rst_ox", ox, 0);
    check("rst_oy", oy, 0);
    check("rst_odata", odata, 0);
    check("rst_vld", odata_vld, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_terr", timeout_err, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Arbitration table: inputs withdrawn before the edge so nothing is pushed
    for (int i = 0; i < 10; i++) begin
      src_vld = tbl[i].vld;
      flush   = tbl[i].flsh;
      @(negedge clk);
      check($sformatf("arb_tbl%0d", i), src_ack, tbl[i].ack);
      src_vld = 3'b000;
      flush   = 1'b0;
      cyc();
    end
    check("arb_no_push", fifo_cnt, 0);

    // Single request: issue two edges after the push
    v0 = vld_cnt;
    src_vld = 3'b010;
    @(negedge clk);
    check("single_ack", src_ack, 3'b010);
    cyc();
    src_vld = 3'b000;
    @(negedge clk);
    check("single_vld_e0", odata_vld, 0);
    check("single_cnt", fifo_cnt, 1);
    cyc();
    @(negedge clk);
    check("single_vld_e1", odata_vld, 1);
    check("single_ox", ox, 7);
    check("single_oy", oy, 3);
    check("single_odata", odata, 8'hff);
    cyc();
    @(negedge clk);
    check("single_vld_drop", odata_vld, 0);
    repeat (2) cyc();
    send_done();
    @(negedge clk);
    check("single_busy_end", busy, 0);
    check("single_pulses", vld_cnt - v0, 1);
    cyc();

    // Priority: tail, head, apple on consecutive cycles
    src_vld = 3'b111;
    @(negedge clk);
    check("prio_ack0", src_ack, 3'b001);
    cyc();
    src_vld = 3'b110;
    @(negedge clk);
    check("prio_ack1", src_ack, 3'b010);
    cyc();
    src_vld = 3'b100;
    @(negedge clk);
    check("prio_ack2", src_ack, 3'b100);
    check("prio_iss_tail_vld", odata_vld, 1);
    check("prio_iss_tail_x", ox, 1);
    check("prio_iss_tail_c", odata, COLOR_BG);
    cyc();
    src_vld = 3'b000;
    for (int k = 1; k < 3; k++) begin
      v0 = vld_cnt;
      repeat (3) cyc();
      check($sformatf("prio_hold%0d", k), vld_cnt - v0, 0);
      send_done();
      wait_issue(6, ok);
      check($sformatf("prio_issue%0d", k), ok, 1);
      check($sformatf("prio_x%0d", k), ox, (k == 1) ? 7 : 20);
      check($sformatf("prio_c%0d", k), odata, (k == 1) ? COLOR_HEAD : COLOR_APPLE);
      cyc();
    end
    send_done();
    repeat (2) cyc();
    check("prio_idle", busy, 0);

    // Full: four queued plus one in flight, fifth source stalls
    push_head(5, 1);
    @(negedge clk);
    check("full_cnt", fifo_cnt, 4);
    check("full_flag", full, 1);
    set_src(SRC_HEAD, 6, 3, COLOR_HEAD);
    src_vld = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("full_noack%0d", i), src_ack, 0);
      cyc();
    end
    send_done();
    @(negedge clk);
    check("full_noack_pop", src_ack, 0);
    cyc();
    @(negedge clk);
    check("full_ack_after", src_ack, 3'b010);
    check("full_iss_vld", odata_vld, 1);
    check("full_iss_x", ox, 2);
    check("full_cnt_after", fifo_cnt, 3);
    cyc();
    src_vld = 3'b000;
    for (int k = 3; k <= 6; k++) begin
      send_done();
      wait_issue(6, ok);
      check($sformatf("full_drain_ok%0d", k), ok, 1);
      check($sformatf("full_drain_x%0d", k), ox, k);
      cyc();
    end
    send_done();
    repeat (2) cyc();
    check("full_idle", busy, 0);
    check("full_terr", timeout_err, 0);

    // Flush while WAITing with three queued entries
    push_head(4, 1);
    check("flush_pre_cnt", fifo_cnt, 3);
    flush = 1'b1;
    set_src(SRC_HEAD, 9, 3, COLOR_HEAD);
    src_vld = 3'b010;
    @(negedge clk);
    check("flush_noack", src_ack, 0);
    cyc();
    flush = 1'b0;
    src_vld = 3'b000;
    @(negedge clk);
    check("flush_cnt", fifo_cnt, 0);
    check("flush_busy_wait", busy, 1);
    v0 = vld_cnt;
    cyc();
    send_done();
    repeat (5) cyc();
    check("flush_no_issue", vld_cnt - v0, 0);
    check("flush_idle", busy, 0);

    // Asynchronous reset mid-WAIT with two queued entries
    push_head(3, 10);
    check("rstm_pre_cnt", fifo_cnt, 2);
    check("rstm_pre_ox", ox, 10);
    rst = 1'b1;
    #1;
    check("rstm_ox", ox, 0);
    check("rstm_oy", oy, 0);
    check("rstm_odata", odata, 0);
    check("rstm_vld", odata_vld, 0);
    check("rstm_cnt", fifo_cnt, 0);
    check("rstm_busy", busy, 0);
    check("rstm_terr", timeout_err, 0);
    cyc();
    rst = 1'b0;
    v0 = vld_cnt;
    send_done();
    repeat (4) cyc();
    check("rstm_no_issue", vld_cnt - v0, 0);
    check("rstm_idle", busy, 0);

`ifdef SPX_REQ_TIMEOUT_EN
    // Watchdog: ten WAIT cycles then IDLE with sticky error, next entry issued
    push_head(2, 1);
    @(negedge clk);
    check("to_first_vld", odata_vld, 1);
    bad = 0;
    repeat (10) begin
      cyc();
      @(negedge clk);
      if (odata_vld) bad++;
    end
    check("to_no_early", bad, 0);
    check("to_err_pre", timeout_err, 0);
    cyc();
    @(negedge clk);
    check("to_err_set", timeout_err, 1);
    cyc();
    @(negedge clk);
    check("to_next_vld", odata_vld, 1);
    check("to_next_x", ox, 2);
    repeat (15) cyc();
    check("to_err_sticky", timeout_err, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/spx_req_queue.md
Name: spx_req_queue

Overview:
- Serialising request queue directly upstream of the superpixel drawing stage.
- Collects superpixel draw requests (logical x, y, colour ID) from three game sources: tail-erase, head-draw and apple-draw.
- Arbitrates between them by fixed priority and buffers them in a small FIFO.
- Issues them one at a time to the drawer using a one-cycle valid pulse, then waits for the drawer's one-cycle done pulse before issuing the next.

Parameters:
- SPIXEL_X_WIDTH, 5, logical x width.
- SPIXEL_Y_WIDTH, 5, logical y width.
- COLOR_ID_WIDTH, 8, colour ID width.
- FIFO_DEPTH, 4, queue entries; must be a power of two and at least 2.
- FIFO_AW, 2, log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 16'd50000, WAIT watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous, active-high reset.
- src_vld  in  3  per-source request; bit0 tail-erase, bit1 head, bit2 apple; held high until acked.
- src_x  in  3*SPIXEL_X_WIDTH  packed x coordinates; source i occupies slice [i*SPIXEL_X_WIDTH +: SPIXEL_X_WIDTH].
- src_y  in  3*SPIXEL_Y_WIDTH  packed y coordinates, same packing.
- src_color  in  3*COLOR_ID_WIDTH  packed colour IDs, same packing.
- src_ack  out  3  combinational one-hot grant; the request is written at the clock edge ending the ack cycle.
- flush  in  1  synchronous discard of all queued entries.
- ox  out  SPIXEL_X_WIDTH  issued x.
- oy  out  SPIXEL_Y_WIDTH  issued y.
- odata  out  COLOR_ID_WIDTH  issued colour.
- odata_vld  out  1  one-cycle issue pulse to the drawer.
- idone  in  1  one-cycle completion pulse from the drawer.
- busy  out  1  high when state is not IDLE or the FIFO is non-empty.
- fifo_cnt  out  FIFO_AW+1  number of occupied entries.
- full  out  1  fifo_cnt equals FIFO_DEPTH.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset: every output register is 0 (ox, oy, odata, odata_vld, timeout_err); FIFO is empty with fifo_cnt=0; state is IDLE.
- Reset asserted mid-operation drops all queued and in-flight requests. Any later idone is ignored because the state is IDLE.

Arbitration:
- src_ack = lowest-index set bit of src_vld, gated by !full && !flush. At most one bit is set.
- Tail-erase has the highest priority, so an erase is always issued before a draw presented in the same cycle.

FIFO:
- Circular buffer with wrapping read and write pointers plus a count.
- Push and pop in the same cycle are both allowed; fifo_cnt is unchanged in that case.
- When full, no ack is given and sources keep holding their request. There is no overflow path.
- Pop from an empty FIFO never occurs.

Issue FSM:
- IDLE: if the FIFO is non-empty, pop the head entry into ox/oy/odata, set odata_vld=1 and go to ISSUE.
- ISSUE: clear odata_vld. If idone=1, go to IDLE; otherwise go to WAIT.
- WAIT: on idone=1, go to IDLE.
- idone received in IDLE is ignored.
- ox/oy/odata hold their value until the next pop.

Latency:
- Push at edge E0 into an empty FIFO while the FSM is IDLE gives odata_vld high in the cycle following edge E1.
- An idone arriving in the cycle after the issue allows a back-to-back issue with one IDLE cycle between pulses.

Flush:
- Clears the FIFO pointers and count at the next edge.
- Suppresses acks and pushes in the flush cycle.
- Does not abort ISSUE or WAIT; the in-flight request still waits for idone.

Simultaneous events:
- Flush together with a pop in IDLE: the flush wins and no issue occurs.

Optional Feature:
- Macro: SPX_REQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE and timeout_err is set.
  - timeout_err stays set until rst.
- Undefined:
  - There is no counter; WAIT is held indefinitely.
  - timeout_err is tied to 0.

Decomposition:
- Shared package spx_pkg contains:
  - width constants: SPIXEL_X_WIDTH, SPIXEL_Y_WIDTH, COLOR_ID_WIDTH;
  - colour constants: COLOR_APPLE=8'h11, COLOR_HEAD=8'hff, COLOR_BG=8'h0f;
  - source indices: SRC_TAIL=0, SRC_HEAD=1, SRC_APPLE=2;
  - the FSM state enum: IDLE, ISSUE, WAIT.
- One natural sub-module, spx_req_fifo: a generic synchronous FIFO with push, pop, flush, count and full.
- Arbiter and FSM stay in the top level.

Test Plan:
- Single request: src_vld=3'b010, x=5'd7, y=5'd3, colour=8'hff, held one cycle. Required: src_ack=3'b010; odata_vld pulses once, 2 edges after the push, with ox=7, oy=3, odata=ff. Then idone 4 cycles later leads to IDLE with busy=0.
- Priority: all three sources requesting with the FIFO empty. Required: acks are 001, 010, 100 on consecutive cycles; issue order is tail, head, apple, each issue waiting for its own idone.
- Full: withhold idone and push 5 requests. Required: fifo_cnt reaches 4 (plus 1 in flight) and full=1; the 5th source sees no ack while held; its ack appears the cycle after idone frees a slot.
- Flush: 3 entries queued while in WAIT; pulse flush. Required: fifo_cnt=0 next cycle; after idone, no further odata_vld pulses.
- Reset mid-WAIT with 2 entries queued. Required: all outputs 0 and fifo_cnt=0 immediately; a following idone produces no issue.
- With SPX_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=10: issue one request and never send idone. Required: after 10 WAIT cycles the FSM returns to IDLE, timeout_err=1 and stays 1; the next queued entry is then issued.
